// File: rtl/ov7670_capture.sv
// rtl/ov7670_capture.sv - OV7670 DVP pixel capture: oversampled camera bus to RGB565 pixel stream
// Camera inputs are treated as data: 2-FF sync, registered edge events, then a single capture FSM.
module ov7670_capture #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SKIP_FRAMES = 2
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        cfg_done,
    input  logic        cam_pclk,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        frame_start,
    output logic        frame_end,
    output logic [7:0]  frame_cnt,
    output logic        line_err
);

    localparam logic [9:0] H_MAX    = 10'(H_ACTIVE);
    localparam logic [9:0] V_MAX    = 10'(V_ACTIVE);
    localparam logic [3:0] SKIP_MAX = 4'(SKIP_FRAMES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SKIP,
        ST_CAPTURE
    } state_t;

    logic [2:0] pclk_sync_q;
    logic [2:0] vsync_sync_q;
    logic [2:0] href_sync_q;
    logic [7:0] data_s1_q;
    logic [7:0] data_s2_q;

    logic       pclk_rise_q;
    logic       vs_rise_q;
    logic       vs_fall_q;
    logic       href_fall_q;
    logic       href_lvl_q;
    logic [7:0] data_q;

    state_t     state_q;
    logic [9:0] x_q;
    logic [9:0] y_q;
    logic       phase_q;
    logic [7:0] hi_q;
    logic [3:0] skip_q;

    logic [15:0] pix_data_q;
    logic        pix_valid_q;
    logic [9:0]  pix_x_q;
    logic [9:0]  pix_y_q;
    logic        frame_start_q;
    logic        frame_end_q;
    logic [7:0]  frame_cnt_q;
    logic        line_err_q;

    // Index 0 is s1, 1 is s2, 2 is the edge-detect stage s3.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            pclk_sync_q  <= '0;
            vsync_sync_q <= '0;
            href_sync_q  <= '0;
            data_s1_q    <= '0;
            data_s2_q    <= '0;
            pclk_rise_q  <= 1'b0;
            vs_rise_q    <= 1'b0;
            vs_fall_q    <= 1'b0;
            href_fall_q  <= 1'b0;
            href_lvl_q   <= 1'b0;
            data_q       <= '0;
        end else begin
            pclk_sync_q  <= {pclk_sync_q[1:0], cam_pclk};
            vsync_sync_q <= {vsync_sync_q[1:0], cam_vsync};
            href_sync_q  <= {href_sync_q[1:0], cam_href};
            data_s1_q    <= cam_data;
            data_s2_q    <= data_s1_q;
            pclk_rise_q  <= pclk_sync_q[1] & ~pclk_sync_q[2];
            vs_rise_q    <= vsync_sync_q[1] & ~vsync_sync_q[2];
            vs_fall_q    <= ~vsync_sync_q[1] & vsync_sync_q[2];
            href_fall_q  <= ~href_sync_q[1] & href_sync_q[2];
            href_lvl_q   <= href_sync_q[1];
            data_q       <= data_s2_q;
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            phase_q       <= 1'b0;
            hi_q          <= '0;
            skip_q        <= '0;
            pix_data_q    <= '0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            frame_cnt_q   <= '0;
            line_err_q    <= 1'b0;
        end else begin
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            if (!cfg_done) begin
                // Abort without a frame_end; frame_cnt and line_err survive.
                state_q <= ST_IDLE;
                x_q     <= '0;
                y_q     <= '0;
                phase_q <= 1'b0;
                skip_q  <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_SKIP;
                    end
                    ST_SKIP: begin
                        if (vs_fall_q) begin
                            if (skip_q == SKIP_MAX) begin
                                state_q       <= ST_CAPTURE;
                                frame_start_q <= 1'b1;
                                skip_q        <= '0;
                            end else begin
                                skip_q <= skip_q + 4'd1;
                            end
                        end
                    end
                    ST_CAPTURE: begin
                        if (vs_rise_q) begin
                            frame_end_q <= 1'b1;
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                            x_q         <= '0;
                            y_q         <= '0;
                            phase_q     <= 1'b0;
                        end else if (vs_fall_q) begin
                            frame_start_q <= 1'b1;
                            x_q           <= '0;
                            y_q           <= '0;
                            phase_q       <= 1'b0;
                        end else if (href_fall_q) begin
                            if (x_q != H_MAX || phase_q) begin
                                line_err_q <= 1'b1;
                            end
                            x_q     <= '0;
                            phase_q <= 1'b0;
                            if (y_q != V_MAX) begin
                                y_q <= y_q + 10'd1;
                            end
                        end else if (pclk_rise_q && href_lvl_q) begin
                            phase_q <= ~phase_q;
                            if (!phase_q) begin
                                hi_q <= data_q;
                            end else begin
                                if (y_q < V_MAX && x_q < H_MAX) begin
                                    pix_valid_q <= 1'b1;
                                    pix_data_q  <= {hi_q, data_q};
                                    pix_x_q     <= x_q;
                                    pix_y_q     <= y_q;
                                end
                                if (x_q != H_MAX) begin
                                    x_q <= x_q + 10'd1;
                                end
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign pix_data    = pix_data_q;
    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign frame_cnt   = frame_cnt_q;
    assign line_err    = line_err_q;

endmodule

// File: doc/ov7670_capture.md
# ov7670_capture

Pixel-capture stage downstream of the OV7670 register-initialisation block: it stays idle until the initialiser's `finish` flag is high, then locks onto the camera's DVP output (PCLK/VSYNC/HREF/D[7:0]). It assembles RGB565 byte pairs into 16-bit pixels with x/y coordinates and frame markers, all in the system clock domain. Camera signals are oversampled, not used as clocks, so the block has a single clock.

## Interface

- `H_ACTIVE`, 640: pixels per line expected (byte pairs per HREF window)
- `V_ACTIVE`, 480: lines per frame captured; lines beyond this are dropped
- `SKIP_FRAMES`, 2: full frames discarded after `cfg_done` before capture starts (0..15)

- `clk_in` in 1: system clock; must be ≥ 3× cam_pclk frequency
- `rst` in 1: asynchronous, active-low reset
- `cfg_done` in 1: level; driven by the initialiser's `finish`
- `cam_pclk` in 1: camera pixel clock, sampled as data
- `cam_vsync` in 1: camera frame sync, active-high pulse between frames
- `cam_href` in 1: camera line-valid, active-high
- `cam_data` in 8: camera byte bus
- `pix_data` out 16: {first byte, second byte} of the current pixel
- `pix_valid` out 1: one-cycle strobe; `pix_data`/`pix_x`/`pix_y` valid
- `pix_x` out 10: column of the current pixel, 0..H_ACTIVE-1
- `pix_y` out 10: row of the current pixel, 0..V_ACTIVE-1
- `frame_start` out 1: one-cycle pulse at the start of each captured frame
- `frame_end` out 1: one-cycle pulse at the end of each captured frame
- `frame_cnt` out 8: captured-frame count, wraps 255→0
- `line_err` out 1: sticky; a line closed with pixel count ≠ H_ACTIVE or with an odd byte count

## Operation

- Input sync: `cam_pclk`, `cam_vsync`, `cam_href`, and `cam_data` each pass through a 2-FF synchroniser. A third stage on pclk/vsync/href provides edge detection.
- Edge definitions: `pclk_rise` = s2 & ~s3. vsync and href rise/fall are detected the same way. Data used is the s2-stage value, aligned with `pclk_rise`.
- FSM states:
  - IDLE: all counters held at 0. Go to SKIP when `cfg_done`=1.
  - SKIP: each vsync falling edge increments skip_cnt. On the falling edge where skip_cnt == SKIP_FRAMES, go to CAPTURE, pulse `frame_start`, and clear skip_cnt. With SKIP_FRAMES=0, the first vsync fall enters CAPTURE.
  - CAPTURE:
    - On each `pclk_rise` with href=1, toggle byte phase. Phase 0 latches the high byte. Phase 1 drives `pix_data`={hi,lo} and pulses `pix_valid` if `pix_y` < V_ACTIVE and `pix_x` < H_ACTIVE; x then increments, saturating at H_ACTIVE.
    - On href fall: if the pixel count ≠ H_ACTIVE or phase=1, set `line_err`. Clear x and phase. Increment y (saturating at V_ACTIVE).
    - On vsync rise: pulse `frame_end`, increment `frame_cnt`, clear x/y/phase.
    - On vsync fall: pulse `frame_start`. Capture is continuous frame to frame.
- `cfg_done` falling in any state: go to IDLE next cycle and clear x, y, phase, and skip_cnt. No `frame_end` is issued; `frame_cnt` and `line_err` are kept.
- Simultaneous events in one cycle: vsync edge handling takes priority over href fall, which takes priority over pclk. A pclk byte coincident with a vsync edge is dropped.
- Outputs `pix_x`/`pix_y` hold the coordinate of the pixel being presented, not the next one.

## Timing

- Reset (`rst`=0, async): state=IDLE; `pix_data`=0, `pix_valid`=0, `pix_x`=0, `pix_y`=0, `frame_start`=0, `frame_end`=0, `frame_cnt`=0, `line_err`=0.
- Latency: `pix_valid` is high in the 4th `clk_in` cycle after the first `clk_in` edge that samples `cam_pclk` high for the second byte (2 sync + 1 edge + 1 output register).
- `frame_start` and `frame_end` have the same 4-cycle latency from vsync fall and rise respectively.
- `pix_valid`, `frame_start`, and `frame_end` are each exactly one `clk_in` cycle wide. `pix_valid` is never asserted in IDLE or SKIP.
- Minimum spacing between `pix_valid` strobes is 2 pclk periods.
- `cam_pclk` high and low phases must each be ≥ 1 `clk_in` period. `cam_data` must be stable for ≥ 2 `clk_in` cycles around the pclk rising edge.

## Test plan

- Reset and idle: hold `cfg_done`=0 and drive 3 full frames → no `pix_valid`, no `frame_start`; all outputs 0.
- Frame skip: `cfg_done`=1, SKIP_FRAMES=2, drive 4 frames → first `frame_start` after the 3rd vsync fall; `frame_cnt`=2 after the 4th frame's vsync rise.
- Pixel assembly (H_ACTIVE=4, V_ACTIVE=2): drive bytes 0x12,0x34,0x56,0x78 … → `pix_data`=0x1234 at (0,0) and 0x5678 at (1,0); 8 strobes per frame; last strobe at (3,1).
- Error lines:
  - Line of 3 pixels (6 bytes) → `line_err`=1 and stays 1; next line still starts at x=0.
  - Line of 5 bytes → `line_err`=1; odd byte discarded.
- Overlong frame: 3 lines at V_ACTIVE=2 → third line produces no `pix_valid`; `frame_end` still fires once.
- Mid-frame abort: drop `cfg_done` during line 1 → `pix_valid` stops within 1 cycle and state returns to IDLE. Reassert `cfg_done` → SKIP restarts with a full SKIP_FRAMES count.
